// File: rtl/pipearch_merge_if.sv
// Line-stream bundle for the gather engine: three source streams in, one destination stream out.
// The engine uses the slave view; the driving/consuming side uses the master view.
interface pipearch_merge_if #(
  parameter int WIDTH   = 512,
  parameter int NUM_SRC = 3
);
  logic [NUM_SRC-1:0]            in_valid;
  logic [NUM_SRC-1:0][WIDTH-1:0] in_data;
  logic [NUM_SRC-1:0]            in_ready;
  logic                          out_valid;
  logic [WIDTH-1:0]              out_data;
  logic                          out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pipearch_merge.sv
// Gather engine: emits num_lines lines from each enabled source, in ascending source order,
// onto one registered destination stream, then pulses op_done once the last line is taken.
module pipearch_merge #(
  parameter int WIDTH   = 512,
  parameter int NUM_SRC = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  op_start,
  output logic                  op_done,
  input  logic [2:0][31:0]      regs,
  output logic [NUM_SRC-1:0]    src_trigger,
  output logic [31:0]           src_configreg,
  output logic                  dst_trigger,
  output logic [31:0]           dst_configreg,
  output logic [17:0]           merged_lines,
  pipearch_merge_if.slave       bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_MERGE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]           state_reg;
  logic [15:0]          num_lines_reg;
  logic [NUM_SRC-1:0]   mask_reg;
  logic [1:0]           cur_reg;
  logic [15:0]          line_cnt_reg;
  logic [17:0]          merged_reg;
  logic                 out_valid_reg;
  logic [WIDTH-1:0]     out_data_reg;
  logic                 op_done_reg;
  logic [NUM_SRC-1:0]   src_trigger_reg;
  logic                 dst_trigger_reg;
  logic [31:0]          src_cfg_reg;
  logic [31:0]          dst_cfg_reg;

  logic [NUM_SRC-1:0]   ready_vec;
  logic [NUM_SRC-1:0]   xfer_vec;
  logic                 xfer;
  logic                 out_free;
  logic [WIDTH-1:0]     sel_data;
  logic [1:0]           first_idx;
  logic [1:0]           next_idx;
  logic                 next_found;
  logic                 last_line;

  // The output slot can take a new line when empty or being emptied this cycle.
  assign out_free = !out_valid_reg || bus.out_ready;

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    assign ready_vec[gi] = (state_reg == S_MERGE) && (cur_reg == 2'(gi)) && out_free;
    assign xfer_vec[gi]  = bus.in_valid[gi] && ready_vec[gi];
  end

  assign xfer      = |xfer_vec;
  assign last_line = (line_cnt_reg == num_lines_reg - 16'd1);

  always_comb begin
    sel_data   = '0;
    first_idx  = 2'd0;
    next_idx   = cur_reg;
    next_found = 1'b0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (cur_reg == 2'(i)) sel_data = bus.in_data[i];
      if (regs[2][i]) first_idx = 2'(i);
      // Scanning downward leaves the lowest enabled index above cur_reg.
      if (mask_reg[i] && (i > int'(cur_reg))) begin
        next_found = 1'b1;
        next_idx   = 2'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= S_IDLE;
      num_lines_reg   <= '0;
      mask_reg        <= '0;
      cur_reg         <= '0;
      line_cnt_reg    <= '0;
      merged_reg      <= '0;
      out_valid_reg   <= 1'b0;
      out_data_reg    <= '0;
      op_done_reg     <= 1'b0;
      src_trigger_reg <= '0;
      dst_trigger_reg <= 1'b0;
      src_cfg_reg     <= '0;
      dst_cfg_reg     <= '0;
    end else begin
      op_done_reg     <= 1'b0;
      src_trigger_reg <= '0;
      dst_trigger_reg <= 1'b0;

      if (xfer) begin
        out_valid_reg <= 1'b1;
        out_data_reg  <= sel_data;
      end else if (bus.out_ready) begin
        out_valid_reg <= 1'b0;
      end

      case (state_reg)
        S_IDLE: begin
          if (op_start) begin
            num_lines_reg <= regs[0][15:0];
            mask_reg      <= regs[2][NUM_SRC-1:0];
            src_cfg_reg   <= regs[0];
            dst_cfg_reg   <= regs[1];
            line_cnt_reg  <= '0;
            merged_reg    <= '0;
            // Nothing to move: complete without touching any channel.
            if (regs[2][NUM_SRC-1:0] == '0 || regs[0][15:0] == 16'd0) begin
              op_done_reg <= 1'b1;
            end else begin
              src_trigger_reg <= regs[2][NUM_SRC-1:0];
              dst_trigger_reg <= 1'b1;
              cur_reg         <= first_idx;
              state_reg       <= S_MERGE;
            end
          end
        end
        S_MERGE: begin
          if (xfer) begin
            merged_reg <= merged_reg + 18'd1;
            if (last_line) begin
              line_cnt_reg <= '0;
              if (next_found) cur_reg   <= next_idx;
              else            state_reg <= S_DRAIN;
            end else begin
              line_cnt_reg <= line_cnt_reg + 16'd1;
            end
          end
        end
        S_DRAIN: begin
          if (out_free) begin
            op_done_reg <= 1'b1;
            state_reg   <= S_IDLE;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready   = ready_vec;
  assign bus.out_valid  = out_valid_reg;
  assign bus.out_data   = out_data_reg;
  assign op_done        = op_done_reg;
  assign src_trigger    = src_trigger_reg;
  assign dst_trigger    = dst_trigger_reg;
  assign src_configreg  = src_cfg_reg;
  assign dst_configreg  = dst_cfg_reg;
  assign merged_lines   = merged_reg;

endmodule

// File: doc/pipearch_merge.md
# pipearch_merge

Gather engine: concatenates line streams from up to three source regions into a single destination stream, the inverse of the one-to-many copy engine. Sits in the instruction pipeline beside the copy unit. It is started by the same op_start/regs decode and reports completion with a one-cycle op_done pulse. Each source and the destination use a valid/ready line handshake fed by the region read/write channels.

## Interface
Parameters:
- WIDTH, 512, line width in bits (CLDATA_WIDTH).
- NUM_SRC, 3, number of source streams (fixed at 3 in this revision).

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- op_start  in  1  start pulse; sampled only in IDLE.
- op_done  out  1  one-cycle completion pulse.
- regs  in  32 x 3  regs[0] = source access properties, with lines per source in [15:0]; regs[1] = destination access properties; regs[2][2:0] = source enable mask.
- src_trigger  out  3  one-cycle start pulse to each enabled source read channel.
- src_configreg  out  32  latched regs[0]; shared by all sources.
- dst_trigger  out  1  one-cycle start pulse to the destination write channel.
- dst_configreg  out  32  latched regs[1].
- in_valid  in  3  per-source line valid.
- in_data  in  WIDTH x 3  per-source line data.
- in_ready  out  3  per-source ready (combinational).
- out_valid  out  1  destination line valid (registered).
- out_data  out  WIDTH  destination line data (registered).
- out_ready  in  1  destination accepts line.
- merged_lines  out  18  total lines emitted in the current/last operation.

## Operation
- States: IDLE, MERGE, DRAIN.
- IDLE, op_start=1:
  - Latch num_lines=regs[0][15:0], mask=regs[2][2:0], src_configreg=regs[0], dst_configreg=regs[1].
  - Clear line_cnt (16b) and merged_lines.
  - If mask==0 or num_lines==0: pulse op_done next cycle, no triggers, stay IDLE.
  - Otherwise: pulse src_trigger[i]=mask[i], pulse dst_trigger, set cur = lowest set bit of mask, go to MERGE.
- op_start is ignored outside IDLE.
- MERGE:
  - in_ready[cur] = !out_valid || out_ready; in_ready of every other source is 0.
  - Transfer on in_valid[cur] && in_ready[cur]: out_data <= in_data[cur], out_valid <= 1, merged_lines++, line_cnt++.
  - On a transfer with line_cnt == num_lines-1: line_cnt <= 0; cur <= next higher set mask bit.
  - If there is no higher set bit, go to DRAIN.
  - Sources are emitted strictly in index order, never interleaved.
- Output register:
  - out_valid clears on out_ready when no new transfer occurs in the same cycle.
  - A simultaneous out handshake and in transfer keeps out_valid=1 with the new data.
- DRAIN:
  - in_ready=0.
  - When out_valid==0, or out_valid && out_ready, pulse op_done in the following cycle and go to IDLE.
- Arithmetic:
  - line_cnt compare is 16-bit unsigned.
  - merged_lines is 18-bit and cannot overflow (max 3 x 65535).
  - merged_lines holds its value after op_done until the next accepted op_start.

## Timing
- Reset values:
  - op_done, src_trigger, dst_trigger, in_ready, out_valid, merged_lines are 0.
  - out_data, src_configreg, dst_configreg are 0.
  - State is IDLE.
- Reset mid-operation aborts immediately. No op_done is issued and out_valid drops asynchronously.
- Triggers and the configreg values are valid in the cycle after op_start.
- in-to-out latency is 1 cycle. Throughput is 1 line/cycle with out_ready held high, including across source switches (no bubble).
- op_done is asserted exactly 1 cycle after the final out handshake.
- Backpressure: with out_ready=0 and out_valid=1, in_ready[cur]=0 and out_data is held stable.
- Source switch: the line after the last line of source i is taken from the next enabled source in the very next cycle.

## Test plan
- mask=3'b111, num_lines=4, all sources always valid, out_ready=1 -> 12 lines out on 12 consecutive cycles, ordered src0 x4, src1 x4, src2 x4; op_done 1 cycle after the 12th; merged_lines=12.
- mask=3'b101, num_lines=2 -> src_trigger=3'b101; in_ready[1] never asserted; output is src0,src0,src2,src2; merged_lines=4.
- mask=3'b010, num_lines=3, out_ready toggled 1/0 every cycle -> no line lost or duplicated; out_data stable while stalled; op_done after the 3rd accepted line.
- mask=0, or num_lines=0 -> op_done pulse 1 cycle after op_start; no triggers; out_valid stays 0.
- Reset asserted after 5 of 8 lines (mask=3'b001) -> outputs 0 immediately; no op_done. A new op_start with num_lines=2 then completes normally with merged_lines=2.
- op_start pulsed again during MERGE -> ignored; the running operation completes with unchanged counts.
